// File: rtl/top_prod_accum_stage.sv
// Product accumulator behind the 13x6 multiplier: tracks beats through its pipeline,
// sums each in_last-terminated group and holds the result on a valid/ready port.
// Optional saturation and overflow reporting: define PROD_ACC_SAT_EN.
module top_prod_accum_stage #(
  parameter int PROD_WIDTH = 18,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int MUL_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  mul_ce,
  input  logic [PROD_WIDTH-1:0] mul_dout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_sum,
  output logic [CNT_WIDTH-1:0]  out_cnt,
  output logic                  out_ovf
);

  // state | meaning
  // ACCUM | summing the current group, out_valid low
  // HOLD  | result presented, out_valid high until out_ready
  typedef enum logic {ACCUM, HOLD} state_t;

  state_t               state, state_nxt;
  logic                 stall, ce;
  logic [MUL_LAT-1:0]   v_pipe, l_pipe;
  logic                 tail, tail_last;
  logic [ACC_WIDTH-1:0] acc, acc_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 ovf_nxt;

  assign out_valid = (state == HOLD);
  assign stall     = out_valid & ~out_ready;
  assign ce        = ~stall;
  assign in_ready  = ce;
  assign mul_ce    = ce;

  assign tail      = v_pipe[MUL_LAT-1] & ce;
  assign tail_last = tail & l_pipe[MUL_LAT-1];
  assign cnt_nxt   = cnt + CNT_WIDTH'(1);

`ifdef PROD_ACC_SAT_EN
  logic                 ovf;
  logic [ACC_WIDTH:0]   sum_raw;

  assign sum_raw = {1'b0, acc} + (ACC_WIDTH+1)'(mul_dout);
  assign acc_nxt = sum_raw[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_raw[ACC_WIDTH-1:0];
  assign ovf_nxt = ovf | sum_raw[ACC_WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (tail_last) begin
      ovf <= 1'b0;
    end else if (tail) begin
      ovf <= ovf_nxt;
    end
  end
`else
  assign acc_nxt = acc + ACC_WIDTH'(mul_dout);
  assign ovf_nxt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ACCUM;
    else       state <= state_nxt;
  end

  // In HOLD a last tail arriving on the release cycle reloads the result with no bubble.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ACCUM:   if (tail_last) state_nxt = HOLD;
      HOLD:    if (ce && !tail_last) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v_pipe  <= '0;
      l_pipe  <= '0;
      acc     <= '0;
      cnt     <= '0;
      out_sum <= '0;
      out_cnt <= '0;
      out_ovf <= 1'b0;
    end else if (ce) begin
      v_pipe <= {v_pipe[MUL_LAT-2:0], in_valid};
      l_pipe <= {l_pipe[MUL_LAT-2:0], in_last};
      if (tail_last) begin
        out_sum <= acc_nxt;
        out_cnt <= cnt_nxt;
        out_ovf <= ovf_nxt;
        acc     <= '0;
        cnt     <= '0;
      end else if (tail) begin
        acc <= acc_nxt;
        cnt <= cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_top_prod_accum_stage.sv
// Directed bench for top_prod_accum_stage: two instances (ACC_WIDTH 32 and 20), each fed
// by a behavioural 2-stage 13x6 multiplier whose 19-bit product is cut to the 18-bit bus.
module tb_top_prod_accum_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_last, out_ready;
  logic [12:0] din0;
  logic [5:0]  din1;

  logic        in_ready, mul_ce, out_valid, out_ovf;
  logic [17:0] mul_dout;
  logic [31:0] out_sum;
  logic [15:0] out_cnt;

  logic        n_in_ready, n_mul_ce, n_out_valid, n_out_ovf;
  logic [17:0] n_mul_dout;
  logic [19:0] n_out_sum;
  logic [15:0] n_out_cnt;

  logic [17:0] m_s1, n_s1;
  logic [18:0] full_prod;

  int n_checks = 0;
  int errors   = 0;

  always #5 clk = ~clk;

  top_prod_accum_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .mul_ce(mul_ce), .mul_dout(mul_dout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cnt(out_cnt), .out_ovf(out_ovf)
  );

  top_prod_accum_stage #(.ACC_WIDTH(20)) dut20 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last),
    .in_ready(n_in_ready), .mul_ce(n_mul_ce), .mul_dout(n_mul_dout),
    .out_valid(n_out_valid), .out_ready(out_ready), .out_sum(n_out_sum),
    .out_cnt(n_out_cnt), .out_ovf(n_out_ovf)
  );

  assign full_prod = 19'(din0) * 19'(din1);

  always_ff @(posedge clk) begin
    if (reset) begin
      m_s1 <= '0; mul_dout <= '0; n_s1 <= '0; n_mul_dout <= '0;
    end else begin
      if (mul_ce) begin
        m_s1 <= full_prod[17:0];
        mul_dout <= m_s1;
      end
      if (n_mul_ce) begin
        n_s1 <= full_prod[17:0];
        n_mul_dout <= n_s1;
      end
    end
  end

  // Reference product as seen on the 18-bit product bus.
  function automatic int p18(input int a, input int b);
    return (a * b) % 262144;
  endfunction

  task automatic beat(input int a, input int b, input logic last);
    in_valid = 1'b1; din0 = 13'(a); din1 = 6'(b); in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0; din0 = 13'd4321; din1 = 6'd33;
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL %s timeout: out_valid=%b required 1", name, out_valid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1; din0 = '0; din1 = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b req 0", out_valid); end
    n_checks++; if (out_sum !== 32'd0) begin errors++; $display("FAIL reset_sum got %0d req 0", out_sum); end
    n_checks++; if (out_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d req 0", out_cnt); end
    n_checks++; if (in_ready !== 1'b1 || mul_ce !== 1'b1) begin errors++; $display("FAIL reset_ready got %b/%b req 1/1", in_ready, mul_ce); end
    n_checks++; if (out_ovf !== 1'b0 || n_out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b/%b req 0/0", out_ovf, n_out_ovf); end
  endtask

  task automatic test_group;
    int n, exp;
    exp = p18(100, 3) + p18(200, 5) + p18(8191, 63);
    beat(100, 3, 1'b0);
    beat(200, 5, 1'b0);
    beat(8191, 63, 1'b1);
    wait_valid("group", n);
    n_checks++; if (n !== 2) begin errors++; $display("FAIL group_latency got %0d req 2 cycles after accept edge", n); end
    n_checks++; if (out_sum !== 32'(exp)) begin errors++; $display("FAIL group_sum got %0d req %0d", out_sum, exp); end
    n_checks++; if (out_cnt !== 16'd3) begin errors++; $display("FAIL group_cnt got %0d req 3", out_cnt); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL group_consume got %b req 0", out_valid); end
  endtask

  task automatic test_single;
    int n;
    beat(1, 1, 1'b1);
    wait_valid("single1", n);
    n_checks++; if (out_sum !== 32'd1 || out_cnt !== 16'd1) begin errors++; $display("FAIL single1 got %0d/%0d req 1/1", out_sum, out_cnt); end
    @(posedge clk); #1;
    beat(0, 0, 1'b1);
    wait_valid("single0", n);
    n_checks++; if (out_sum !== 32'd0 || out_cnt !== 16'd1) begin errors++; $display("FAIL single0 got %0d/%0d req 0/1", out_sum, out_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int n;
    beat(10, 2, 1'b1);
    beat(7, 7, 1'b1);
    wait_valid("b2b", n);
    n_checks++; if (out_sum !== 32'd20 || out_cnt !== 16'd1) begin errors++; $display("FAIL b2b_first got %0d/%0d req 20/1", out_sum, out_cnt); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 32'd49) begin errors++; $display("FAIL b2b_second got v=%b sum=%0d req v=1 sum=49", out_valid, out_sum); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b req 0", out_valid); end
  endtask

  task automatic test_stall;
    int n;
    out_ready = 1'b0;
    beat(3, 4, 1'b1);
    beat(2, 2, 1'b0);
    beat(5, 1, 1'b1);
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 32'd12) begin errors++; $display("FAIL stall_held got v=%b sum=%0d req v=1 sum=12", out_valid, out_sum); end
    in_valid = 1'b1; din0 = 13'd6; din1 = 6'd6; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (in_ready !== 1'b0 || mul_ce !== 1'b0 || out_sum !== 32'd12 || out_valid !== 1'b1) begin
        errors++; $display("FAIL stall_cycle%0d got rdy=%b ce=%b v=%b sum=%0d req 0/0/1/12", i, in_ready, mul_ce, out_valid, out_sum);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1; #1;
    n_checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release got %b req 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %b req 0", out_valid); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 32'd9 || out_cnt !== 16'd2) begin errors++; $display("FAIL stall_next got v=%b %0d/%0d req 1 9/2", out_valid, out_sum, out_cnt); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b1 || out_sum !== 32'd36 || out_cnt !== 16'd1) begin errors++; $display("FAIL stall_kept got v=%b %0d/%0d req 1 36/1", out_valid, out_sum, out_cnt); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_end got %b req 0", out_valid); end
  endtask

  task automatic test_bubbles;
    int n;
    beat(4, 4, 1'b0);
    din0 = 13'd99; din1 = 6'd9;
    repeat (2) begin @(posedge clk); #1; end
    beat(5, 5, 1'b1);
    wait_valid("bubbles", n);
    n_checks++; if (out_sum !== 32'd41 || out_cnt !== 16'd2) begin errors++; $display("FAIL bubbles got %0d/%0d req 41/2", out_sum, out_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow;
    int n, exp32, exp20;
    logic exp_ovf;
    exp32 = 8 * p18(8191, 63);
`ifdef PROD_ACC_SAT_EN
    exp20 = 1048575; exp_ovf = 1'b1;
`else
    exp20 = exp32 % 1048576; exp_ovf = 1'b0;
`endif
    for (int i = 0; i < 8; i++) beat(8191, 63, i == 7);
    wait_valid("ovf", n);
    n_checks++; if (out_sum !== 32'(exp32) || out_cnt !== 16'd8 || out_ovf !== 1'b0) begin errors++; $display("FAIL ovf_wide got %0d/%0d/%b req %0d/8/0", out_sum, out_cnt, out_ovf, exp32); end
    n_checks++; if (n_out_sum !== 20'(exp20)) begin errors++; $display("FAIL ovf_sum20 got %0d req %0d", n_out_sum, exp20); end
    n_checks++; if (n_out_ovf !== exp_ovf || n_out_cnt !== 16'd8) begin errors++; $display("FAIL ovf_flag20 got %b/%0d req %b/8", n_out_ovf, n_out_cnt, exp_ovf); end
    @(posedge clk); #1;
    beat(2, 3, 1'b1);
    wait_valid("ovf_clear", n);
    n_checks++; if (n_out_sum !== 20'd6 || n_out_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0d/%b req 6/0", n_out_sum, n_out_ovf); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int n;
    beat(9, 9, 1'b0);
    beat(9, 9, 1'b0);
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || out_sum !== 32'd0 || out_cnt !== 16'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid got v=%b %0d/%0d rdy=%b req 0 0/0 1", out_valid, out_sum, out_cnt, in_ready); end
    beat(3, 3, 1'b1);
    wait_valid("rst_mid_next", n);
    n_checks++; if (out_sum !== 32'd9 || out_cnt !== 16'd1) begin errors++; $display("FAIL rst_mid_next got %0d/%0d req 9/1", out_sum, out_cnt); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    beat(2, 2, 1'b1);
    wait_valid("rst_hold", n);
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || out_sum !== 32'd0 || out_cnt !== 16'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_hold got v=%b %0d/%0d rdy=%b req 0 0/0 1", out_valid, out_sum, out_cnt, in_ready); end
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_group();
    test_single();
    test_back_to_back();
    test_stall();
    test_bubbles();
    test_overflow();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, errors);
    $finish;
  end

endmodule
